// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg: shared constants and types for the MIPS memory-port arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_D_BUSY = 3'd1;
  localparam logic [2:0] ST_I_BUSY = 3'd2;
  localparam logic [2:0] ST_D_DONE = 3'd3;
  localparam logic [2:0] ST_I_DONE = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_D_BUSY = ST_D_BUSY,
    S_I_BUSY = ST_I_BUSY,
    S_D_DONE = ST_D_DONE,
    S_I_DONE = ST_I_DONE,
    S_ERR    = ST_ERR
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/arb_wdog.sv
// -----------------------------------------------------------------------------
// arb_wdog: counts busy cycles without an ack and flags the one reaching TIMEOUT
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module arb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != TOP)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High in the busy cycle whose missing ack would bring the count to TIMEOUT
  assign expired = count_en & ~clear & (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter: shares one req/ack memory port between IF and MEM stages
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_mem,
  output logic              stall_if,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic              if_valid_q, if_valid_d;
  logic              timeout_err_q, timeout_err_d;

  logic wdog_clear;
  logic wdog_count_en;
  logic wdog_expired;

  assign wdog_clear    = (state_q == S_IDLE);
  assign wdog_count_en = ((state_q == S_D_BUSY) || (state_q == S_I_BUSY)) & ~mem_ack;

  arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wdog_clear),
    .count_en (wdog_count_en),
    .expired  (wdog_expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    d_rdata_d   = d_rdata_q;
    if_rdata_d  = if_rdata_q;

    case (state_q)
      // Data wins a tie: it belongs to the older instruction
      S_IDLE: begin
        if (d_read | d_write) begin
          state_d     = S_D_BUSY;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_we_d    = d_write;
        end else if (if_req) begin
          state_d    = S_I_BUSY;
          mem_addr_d = if_addr;
          mem_we_d   = 1'b0;
        end
      end
      S_D_BUSY: begin
        if (mem_ack) begin
          state_d = S_D_DONE;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end else if (wdog_expired) begin
          state_d = S_ERR;
        end
      end
      S_I_BUSY: begin
        if (mem_ack) begin
          state_d    = S_I_DONE;
          if_rdata_d = mem_rdata;
        end else if (wdog_expired) begin
          state_d = S_ERR;
        end
      end
      S_D_DONE: state_d = S_IDLE;
      S_I_DONE: state_d = S_IDLE;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase

    mem_req_d     = (state_d == S_D_BUSY) || (state_d == S_I_BUSY);
    d_valid_d     = (state_d == S_D_DONE);
    if_valid_d    = (state_d == S_I_DONE);
    timeout_err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      d_rdata_q     <= '0;
      if_rdata_q    <= '0;
      d_valid_q     <= 1'b0;
      if_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      d_rdata_q     <= d_rdata_d;
      if_rdata_q    <= if_rdata_d;
      d_valid_q     <= d_valid_d;
      if_valid_q    <= if_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_rdata    = if_rdata_q;
  assign d_valid     = d_valid_q;
  assign if_valid    = if_valid_q;
  assign timeout_err = timeout_err_q;

  assign stall_mem = ((d_read | d_write) & ~d_valid_q) | (state_q == S_ERR);
  assign stall_if  = (if_req & ~if_valid_q) | stall_mem;

endmodule

`default_nettype wire
